// File: rtl/motor_pwm_drive.sv
// -----------------------------------------------------------------------------
// motor_pwm_drive
//
// Receiving end of the wheel-speed interface. Turns the 7-bit left/right
// wheel speed targets and the brake flag into two PWM signals for the
// H-bridge drivers. Duty changes are slew-limited once per PWM period, so a
// step in the target becomes a ramp. Braking acts on the very next clock and
// is never ramped.
//
// Parameters:
//   PRESCALE  - clock cycles per PWM counter tick (>= 1)
//   RAMP_STEP - maximum duty change per PWM period (1..127, 127 = no ramp)
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   en           in   drive enable; low = outputs idle, counters held at 0
//   v_l, v_r     in   7-bit wheel target speeds, 0..127
//   brk          in   brake request, sampled every cycle
//   pwm_l, pwm_r out  registered PWM outputs
//   brk_o        out  short-brake drive to the H-bridges
//   duty_l/_r    out  current ramped duties
//   period_start out  one-cycle pulse the cycle after a period boundary
// -----------------------------------------------------------------------------
module motor_pwm_drive #(
    parameter int PRESCALE  = 8,
    parameter int RAMP_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] v_l,
    input  logic [6:0] v_r,
    input  logic       brk,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       brk_o,
    output logic [6:0] duty_l,
    output logic [6:0] duty_r,
    output logic       period_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [6:0]    CNT_LAST = 7'd126;
    localparam logic [7:0]    STEP     = 8'(RAMP_STEP);

    // Slew-limited move of duty toward target. 8-bit intermediates keep the
    // difference and sum free of wrap; the result is bounded by the target,
    // so it can never leave 0..127.
    function automatic logic [6:0] ramp(input logic [6:0] duty,
                                        input logic [6:0] target);
        logic [7:0] d;
        logic [7:0] t;
        logic [7:0] diff;
        logic [7:0] res;
        d    = {1'b0, duty};
        t    = {1'b0, target};
        diff = 8'd0;
        res  = d;
        if (t > d) begin
            diff = t - d;
            res  = d + ((diff < STEP) ? diff : STEP);
        end else if (t < d) begin
            diff = d - t;
            res  = d - ((diff < STEP) ? diff : STEP);
        end else begin
            res = d;
        end
        return res[6:0];
    endfunction

    logic [PW-1:0] pre_cnt_r;
    logic [6:0]    pwm_cnt_r;
    logic [6:0]    duty_l_r;
    logic [6:0]    duty_r_r;
    logic          pwm_l_r;
    logic          pwm_r_r;
    logic          brk_o_r;
    logic          period_start_r;

    logic [PW-1:0] pre_cnt_s;
    logic [6:0]    pwm_cnt_s;
    logic [6:0]    duty_l_s;
    logic [6:0]    duty_r_s;
    logic          pwm_l_s;
    logic          pwm_r_s;
    logic          brk_o_s;
    logic          period_start_s;
    logic          tick_s;
    logic          boundary_s;

    // Prescaler tick and period boundary decode.
    always_comb begin
        tick_s     = 1'b0;
        boundary_s = 1'b0;
        if (en) begin
            tick_s     = (pre_cnt_r == PRE_LAST);
            boundary_s = tick_s && (pwm_cnt_r == CNT_LAST);
        end else begin
            tick_s     = 1'b0;
            boundary_s = 1'b0;
        end
    end

    // Next-state for counters, duties and registered outputs.
    always_comb begin
        pre_cnt_s      = '0;
        pwm_cnt_s      = 7'd0;
        duty_l_s       = 7'd0;
        duty_r_s       = 7'd0;
        pwm_l_s        = 1'b0;
        pwm_r_s        = 1'b0;
        period_start_s = 1'b0;
        brk_o_s        = brk;
        if (en) begin
            if (tick_s) begin
                pre_cnt_s = '0;
                pwm_cnt_s = (pwm_cnt_r == CNT_LAST) ? 7'd0 : (pwm_cnt_r + 7'd1);
            end else begin
                pre_cnt_s = pre_cnt_r + PW'(1);
                pwm_cnt_s = pwm_cnt_r;
            end
            // Compare uses the current counter/duty, giving one clock of latency.
            pwm_l_s        = (pwm_cnt_r < duty_l_r) && !brk;
            pwm_r_s        = (pwm_cnt_r < duty_r_r) && !brk;
            period_start_s = boundary_s;
            // Brake overrides a coinciding boundary update.
            if (brk) begin
                duty_l_s = 7'd0;
                duty_r_s = 7'd0;
            end else if (boundary_s) begin
                duty_l_s = ramp(duty_l_r, v_l);
                duty_r_s = ramp(duty_r_r, v_r);
            end else begin
                duty_l_s = duty_l_r;
                duty_r_s = duty_r_r;
            end
        end else begin
            pre_cnt_s = '0;
            pwm_cnt_s = 7'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_r      <= '0;
            pwm_cnt_r      <= 7'd0;
            duty_l_r       <= 7'd0;
            duty_r_r       <= 7'd0;
            pwm_l_r        <= 1'b0;
            pwm_r_r        <= 1'b0;
            brk_o_r        <= 1'b0;
            period_start_r <= 1'b0;
        end else begin
            pre_cnt_r      <= pre_cnt_s;
            pwm_cnt_r      <= pwm_cnt_s;
            duty_l_r       <= duty_l_s;
            duty_r_r       <= duty_r_s;
            pwm_l_r        <= pwm_l_s;
            pwm_r_r        <= pwm_r_s;
            brk_o_r        <= brk_o_s;
            period_start_r <= period_start_s;
        end
    end

    assign pwm_l        = pwm_l_r;
    assign pwm_r        = pwm_r_r;
    assign brk_o        = brk_o_r;
    assign duty_l       = duty_l_r;
    assign duty_r       = duty_r_r;
    assign period_start = period_start_r;

endmodule
